// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: FSM encoding and default widths.
package pwm_ctrl_pkg;

  localparam int DUTY_W_DEF  = 8;
  localparam int PERIOD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ramp_tick_timer.sv
// Interval down-counter: loads a period, counts down while enabled and
// raises tick on the cycle the count is 1, reloading on that same edge.
module ramp_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         tick
);

  logic [W-1:0] count;

  assign tick = enable && (count == W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load || tick) begin
      count <= load_val;
    end else if (enable) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a registered PWM duty value toward a requested target in fixed steps,
// one step every cfg_period clocks, with hold, abort and a completion pulse.
//
// Handshake: a request is taken on the rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high only in IDLE, so requests made
// while busy are dropped rather than queued.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DUTY_W   = DUTY_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DUTY_W-1:0]   cfg_target,
  input  logic [DUTY_W-1:0]   cfg_step,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                hold,
  input  logic                abort,
  output logic [DUTY_W-1:0]   pwm_duty_cycle,
  output logic                busy,
  output logic                done,
  output state_t              state_dbg
);

  state_t              state;
  logic [DUTY_W-1:0]   target_q;
  logic [DUTY_W-1:0]   step_q;
  logic [PERIOD_W-1:0] period_q;

  logic                accept;
  logic [DUTY_W-1:0]   eff_step;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] timer_load_val;
  logic                timer_en;
  logic                tick;

  logic [DUTY_W:0]     duty_up;
  logic [DUTY_W:0]     duty_dn;
  logic [DUTY_W-1:0]   next_duty;

  assign accept     = cfg_valid && cfg_ready;
  assign eff_step   = (cfg_step == '0)   ? DUTY_W'(1)   : cfg_step;
  assign eff_period = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;

  assign timer_load_val = accept ? eff_period : period_q;
  assign timer_en       = (state == ST_RAMP) && !abort && !hold;
  assign state_dbg      = state;

  ramp_tick_timer #(.W(PERIOD_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (timer_load_val),
    .enable   (timer_en),
    .tick     (tick)
  );

  // One extra bit catches carry above the max code and borrow below zero.
  assign duty_up = {1'b0, pwm_duty_cycle} + {1'b0, step_q};
  assign duty_dn = {1'b0, pwm_duty_cycle} - {1'b0, step_q};

  always_comb begin
    next_duty = target_q;
    if (pwm_duty_cycle < target_q) begin
      if (duty_up < {1'b0, target_q}) next_duty = duty_up[DUTY_W-1:0];
    end else if (pwm_duty_cycle > target_q) begin
      if (!duty_dn[DUTY_W] && (duty_dn > {1'b0, target_q})) next_duty = duty_dn[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pwm_duty_cycle <= '0;
      target_q       <= '0;
      step_q         <= '0;
      period_q       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_ready      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            target_q  <= cfg_target;
            step_q    <= eff_step;
            period_q  <= eff_period;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            if (cfg_target == pwm_duty_cycle) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (tick) begin
            pwm_duty_cycle <= next_duty;
            if (next_duty == target_q) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: up/down ramps, saturation, hold, abort,
// busy rejection, equal-target requests and mid-ramp reset.
module tb_pwm_ramp_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int PERIOD_W = 16;
  localparam int DUTY_W   = 8;

  logic                clk;
  logic                rst_n;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [DUTY_W-1:0]   cfg_target;
  logic [DUTY_W-1:0]   cfg_step;
  logic [PERIOD_W-1:0] cfg_period;
  logic                hold;
  logic                abort;
  logic [DUTY_W-1:0]   pwm_duty_cycle;
  logic                busy;
  logic                done;
  state_t              state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [DUTY_W-1:0] exp_q[$];

  pwm_ramp_ctrl #(.PERIOD_W(PERIOD_W), .DUTY_W(DUTY_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_target     (cfg_target),
    .cfg_step       (cfg_step),
    .cfg_period     (cfg_period),
    .hold           (hold),
    .abort          (abort),
    .pwm_duty_cycle (pwm_duty_cycle),
    .busy           (busy),
    .done           (done),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drivers: everything changes #1 after a rising edge and is sampled there
  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input logic [DUTY_W-1:0] t, input logic [DUTY_W-1:0] s,
                         input logic [PERIOD_W-1:0] p);
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_step   = s;
    cfg_period = p;
    step_clk(1);
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step_clk(1);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [DUTY_W-1:0] e;
    logic [DUTY_W-1:0] prev;
    int done_cnt;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_target = '0; cfg_step = '0;
    cfg_period = '0; hold = 1'b0; abort = 1'b0;
    step_clk(2);
    rst_n = 1'b1;

    check("rst_duty",  32'(pwm_duty_cycle), 32'd0);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_ready", 32'(cfg_ready),      32'd1);
    check("rst_state", 32'(state_dbg),      32'(ST_IDLE));

    // up-ramp 0 -> 10, step 3, period 4: steps land 4,8,12,16 clocks after acceptance
    exp_q.push_back(8'd3); exp_q.push_back(8'd6);
    exp_q.push_back(8'd9); exp_q.push_back(8'd10);
    prev = 8'd0;
    request(8'd10, 8'd3, 16'd4);
    check("up_busy", 32'(busy), 32'd1);
    check("up_ready", 32'(cfg_ready), 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_clk(3);
      check("up_between", 32'(pwm_duty_cycle), 32'(prev));
      step_clk(1);
      check("up_step", 32'(pwm_duty_cycle), 32'(e));
      prev = e;
    end
    check("up_done", 32'(done), 32'd1);
    check("up_done_busy", 32'(busy), 32'd1);
    step_clk(1);
    check("up_done_clr", 32'(done), 32'd0);
    check("up_idle_busy", 32'(busy), 32'd0);
    check("up_idle_ready", 32'(cfg_ready), 32'd1);

    // climb to 200 with a step that saturates at the target
    request(8'd200, 8'd255, 16'd0);
    step_clk(1);
    check("sat_up_duty", 32'(pwm_duty_cycle), 32'd200);
    check("sat_up_done", 32'(done), 32'd1);
    step_clk(1);

    // down-ramp 200 -> 0, step 255, period 0 (treated as 1): no wrap below 0
    request(8'd0, 8'd255, 16'd0);
    step_clk(1);
    check("dn_duty", 32'(pwm_duty_cycle), 32'd0);
    check("dn_done", 32'(done), 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step_clk(1);
      if (done) done_cnt++;
    end
    check("dn_done_once", 32'(done_cnt), 32'd0);
    check("dn_duty_after", 32'(pwm_duty_cycle), 32'd0);

    // hold: 0 -> 8, step 1, period 5, hold 7 cycles three clocks into an interval
    request(8'd8, 8'd1, 16'd5);
    step_clk(4);
    check("hold_pre", 32'(pwm_duty_cycle), 32'd0);
    step_clk(1);
    check("hold_first", 32'(pwm_duty_cycle), 32'd1);
    step_clk(2);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step_clk(1);
      check("hold_frozen", 32'(pwm_duty_cycle), 32'd1);
    end
    hold = 1'b0;
    step_clk(2);
    check("hold_resume_wait", 32'(pwm_duty_cycle), 32'd1);
    step_clk(1);
    check("hold_resume_step", 32'(pwm_duty_cycle), 32'd2);
    wait_done("hold_done_seen", 40);
    check("hold_final", 32'(pwm_duty_cycle), 32'd8);
    step_clk(1);

    // abort on the cycle the counter is 1, with duty 4
    request(8'd0, 8'd4, 16'd2);
    step_clk(2);
    check("abort_duty4", 32'(pwm_duty_cycle), 32'd4);
    step_clk(1);
    abort = 1'b1;
    step_clk(1);
    abort = 1'b0;
    check("abort_duty", 32'(pwm_duty_cycle), 32'd4);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(cfg_ready), 32'd1);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    step_clk(2);
    check("abort_no_late", 32'(pwm_duty_cycle), 32'd4);

    // busy rejection: a target=99 request during RAMP must be dropped
    request(8'd20, 8'd2, 16'd3);
    step_clk(1);
    cfg_valid  = 1'b1;
    cfg_target = 8'd99;
    step_clk(1);
    cfg_valid  = 1'b0;
    check("rej_busy", 32'(busy), 32'd1);
    wait_done("rej_done_seen", 40);
    check("rej_final", 32'(pwm_duty_cycle), 32'd20);
    step_clk(1);
    check("rej_idle", 32'(busy), 32'd0);

    // equal target: straight to DONE, duty untouched
    request(8'd20, 8'd5, 16'd7);
    check("eq_done", 32'(done), 32'd1);
    check("eq_duty", 32'(pwm_duty_cycle), 32'd20);
    step_clk(1);
    check("eq_done_clr", 32'(done), 32'd0);
    check("eq_busy", 32'(busy), 32'd0);

    // reset for one edge mid-ramp; inputs asserted during reset are ignored
    request(8'd100, 8'd1, 16'd2);
    step_clk(5);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; cfg_valid = 1'b1; cfg_target = 8'd50; abort = 1'b1;
    step_clk(1);
    rst_n = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    check("mrst_duty",  32'(pwm_duty_cycle), 32'd0);
    check("mrst_busy",  32'(busy),           32'd0);
    check("mrst_done",  32'(done),           32'd0);
    check("mrst_ready", 32'(cfg_ready),      32'd1);
    step_clk(3);
    check("mrst_stay_duty", 32'(pwm_duty_cycle), 32'd0);
    check("mrst_stay_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
